id_ex_stage: RTL

- ID/EX pipeline stage directly downstream of the register file in the 5-stage MIPS pipeline.
- Captures decoded operands, immediate, register specifiers and control into the EX stage.
- Detects load-use hazards and inserts one bubble per hazard, holding PC and IF/ID meanwhile.
- Squashes the ID instruction on a taken-branch flush, and counts inserted bubbles for performance debug.

---
 rtl/id_ex_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squash and bubble counter.
// Latency: one cycle from ID inputs to ex_* outputs; stall is combinational in the same cycle.
// Backpressure: stall holds PC and IF/ID for one cycle per load-use pair while a bubble enters EX.
module id_ex_stage #(
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [31:0]       id_read_data1,
    input  logic [31:0]       id_read_data2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              stall,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_write_reg,
    output logic [31:0]       ex_read_data1,
    output logic [31:0]       ex_read_data2,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_count
);

    // Control bundle bit positions.
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_REG_DST   = 2;

    logic              r_ex_valid;
    logic [4:0]        r_ex_rs;
    logic [4:0]        r_ex_rt;
    logic [4:0]        r_ex_write_reg;
    logic [31:0]       r_ex_read_data1;
    logic [31:0]       r_ex_read_data2;
    logic [31:0]       r_ex_imm;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [CNT_W-1:0]  r_bubble_count;

    logic              w_rs_match;
    logic              w_rt_match;
    logic              w_hazard;
    logic              w_stall;
    logic              w_load_bubble;
    logic              w_cnt_sat;

    // A load in EX whose destination is read by the ID instruction; r0 never creates a dependency.
    // No WB bypass is required: the register file writes on negedge, so WB data is already on id_read_data*.
    assign w_rs_match    = id_uses_rs && (id_rs == r_ex_write_reg);
    assign w_rt_match    = id_uses_rt && (id_rt == r_ex_write_reg);
    assign w_hazard      = id_valid && r_ex_valid && r_ex_ctrl[CTRL_MEM_READ] &&
                           (r_ex_write_reg != 5'd0) && (w_rs_match || w_rt_match);
    // Flush wins over the hold so a branch redirect is never lost.
    assign w_stall       = w_hazard && !flush;
    assign w_load_bubble = flush || w_hazard;
    assign w_cnt_sat     = &r_bubble_count;

    // Stage register: a bubble on flush or hazard, otherwise capture the ID instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid      <= 1'b0;
            r_ex_rs         <= 5'd0;
            r_ex_rt         <= 5'd0;
            r_ex_write_reg  <= 5'd0;
            r_ex_read_data1 <= 32'd0;
            r_ex_read_data2 <= 32'd0;
            r_ex_imm        <= 32'd0;
            r_ex_ctrl       <= '0;
        end else if (w_load_bubble) begin
            // Data and specifier fields are don't-care in a bubble and simply hold.
            r_ex_valid     <= 1'b0;
            r_ex_ctrl      <= '0;
            r_ex_write_reg <= 5'd0;
        end else begin
            r_ex_valid      <= id_valid;
            r_ex_rs         <= id_rs;
            r_ex_rt         <= id_rt;
            r_ex_write_reg  <= id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;
            r_ex_read_data1 <= id_read_data1;
            r_ex_read_data2 <= id_read_data2;
            r_ex_imm        <= id_imm;
            r_ex_ctrl       <= id_valid ? id_ctrl : '0;
        end
    end

    // Saturating count of hazard bubbles; flush bubbles are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_count <= '0;
        end else if (w_stall && !w_cnt_sat) begin
            r_bubble_count <= r_bubble_count + 1'b1;
        end
    end

    assign stall         = w_stall;
    assign ex_valid      = r_ex_valid;
    assign ex_rs         = r_ex_rs;
    assign ex_rt         = r_ex_rt;
    assign ex_write_reg  = r_ex_write_reg;
    assign ex_read_data1 = r_ex_read_data1;
    assign ex_read_data2 = r_ex_read_data2;
    assign ex_imm        = r_ex_imm;
    assign ex_ctrl       = r_ex_ctrl;
    assign bubble_count  = r_bubble_count;

    // reg_write only matters downstream; referenced here so the bit map stays documented in one place.
    logic w_unused_reg_write;
    assign w_unused_reg_write = r_ex_ctrl[CTRL_REG_WRITE];

endmodule
